// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle for the register-busy scoreboard.
// Master is decode/issue side; slave is the scoreboard.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16
);
  logic                flush;
  logic                issue_valid;
  logic                issue_writes;
  logic [REG_AW-1:0]   issue_dest;
  logic [REG_AW-1:0]   issue_src1;
  logic [REG_AW-1:0]   issue_src2;
  logic                issue_stall;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_dest;
  logic [NUM_REGS-1:0] busy_mask;
  logic [REG_AW:0]     pending_count;
  logic [CNT_W-1:0]    stall_cycles;
  logic                err_spurious;

  modport master (
    output flush, issue_valid, issue_writes,
    output issue_dest, issue_src1, issue_src2,
    output wb_valid, wb_dest,
    input  issue_stall, busy_mask, pending_count,
    input  stall_cycles, err_spurious
  );

  modport slave (
    input  flush, issue_valid, issue_writes,
    input  issue_dest, issue_src1, issue_src2,
    input  wb_valid, wb_dest,
    output issue_stall, busy_mask, pending_count,
    output stall_cycles, err_spurious
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: tracks in-flight writes, stalls RAW/WAW
// hazards at issue and clears busy bits as writebacks land.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_AW:0]     pend_q, pend_d;
  logic [CNT_W-1:0]    scnt_q, scnt_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff_busy;
  logic                stall;
  logic                accept;

  localparam logic [NUM_REGS-1:0] ONE =
    {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Same-cycle writeback is already readable, so it hides the busy bit.
  always_comb begin
    wb_mask  = '0;
    if (sb.wb_valid)
      wb_mask = ONE << sb.wb_dest;
    wb_mask[0] = 1'b0;
    eff_busy = busy_q & ~wb_mask;
  end

  always_comb begin
    stall = sb.flush;
    if (sb.issue_valid) begin
      if (eff_busy[sb.issue_src1]
          || eff_busy[sb.issue_src2]
          || (sb.issue_writes && eff_busy[sb.issue_dest]))
        stall = 1'b1;
    end
    accept = sb.issue_valid & ~stall;
  end

  always_comb begin
    set_mask = '0;
    if (accept && sb.issue_writes)
      set_mask = ONE << sb.issue_dest;
    set_mask[0] = 1'b0;
  end

  // Set wins over clear so a re-issued writer keeps the register busy.
  always_comb begin
    busy_d = (busy_q & ~wb_mask) | set_mask;
    if (sb.flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      pend_d = pend_d + {{REG_AW{1'b0}}, busy_d[i]};
  end

  always_comb begin
    scnt_d = scnt_q;
    if (sb.issue_valid && stall && !sb.flush && !(&scnt_q))
      scnt_d = scnt_q + 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (sb.wb_valid && (sb.wb_dest != '0)
        && !busy_q[sb.wb_dest] && !sb.flush)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      pend_q <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      scnt_q <= scnt_d;
      err_q  <= err_d;
    end
  end

  assign sb.issue_stall   = stall;
  assign sb.busy_mask     = busy_q;
  assign sb.pending_count = pend_q;
  assign sb.stall_cycles  = scnt_q;
  assign sb.err_spurious  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Inputs change #1 after posedge; outputs sampled then.
module tb_reg_scoreboard;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [15:0] exp_cnt;

  reg_scoreboard_if #(.NUM_REGS(32), .REG_AW(5), .CNT_W(16)) sb ();

  reg_scoreboard #(
    .NUM_REGS(32), .REG_AW(5), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb.flush        = 1'b0;
    sb.issue_valid  = 1'b0;
    sb.issue_writes = 1'b0;
    sb.issue_dest   = 5'd0;
    sb.issue_src1   = 5'd0;
    sb.issue_src2   = 5'd0;
    sb.wb_valid     = 1'b0;
    sb.wb_dest      = 5'd0;
  endtask

  task automatic issue(input logic w, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2);
    sb.issue_valid  = 1'b1;
    sb.issue_writes = w;
    sb.issue_dest   = d;
    sb.issue_src1   = s1;
    sb.issue_src2   = s2;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (sb.busy_mask !== 32'h0) begin
      failures++;
      $display("FAIL reset_busy got=%h exp=%h", sb.busy_mask, 32'h0);
    end
    checks++;
    if (sb.pending_count !== 6'd0) begin
      failures++;
      $display("FAIL reset_pend got=%0d exp=0", sb.pending_count);
    end
    checks++;
    if (sb.issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", sb.issue_stall);
    end
    checks++;
    if (sb.stall_cycles !== 16'h0) begin
      failures++;
      $display("FAIL reset_cnt got=%h exp=0", sb.stall_cycles);
    end
    checks++;
    if (sb.err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", sb.err_spurious);
    end
    exp_cnt = 16'h0;
  endtask

  task automatic test_raw();
    issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1;
    checks++;
    if (sb.issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL raw_first_stall got=%b exp=0", sb.issue_stall);
    end
    step();
    checks++;
    if (sb.busy_mask !== 32'h20) begin
      failures++;
      $display("FAIL raw_busy got=%h exp=%h", sb.busy_mask, 32'h20);
    end
    issue(1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    checks++;
    if (sb.issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL raw_stall got=%b exp=1", sb.issue_stall);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (sb.stall_cycles !== exp_cnt) begin
      failures++;
      $display("FAIL raw_cnt1 got=%h exp=%h", sb.stall_cycles, exp_cnt);
    end
    step();
    exp_cnt = exp_cnt + 16'd1;
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd5;
    #1;
    checks++;
    if (sb.issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL raw_wb_bypass got=%b exp=0", sb.issue_stall);
    end
    step();
    idle_inputs();
    checks++;
    if (sb.busy_mask !== 32'h0) begin
      failures++;
      $display("FAIL raw_clear got=%h exp=0", sb.busy_mask);
    end
    checks++;
    if (sb.stall_cycles !== exp_cnt) begin
      failures++;
      $display("FAIL raw_cnt2 got=%h exp=%h", sb.stall_cycles, exp_cnt);
    end
    checks++;
    if (sb.err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL raw_err got=%b exp=0", sb.err_spurious);
    end
  endtask

  task automatic test_set_over_clear();
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    step();
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd7;
    #1;
    checks++;
    if (sb.issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL soc_stall got=%b exp=0", sb.issue_stall);
    end
    step();
    idle_inputs();
    checks++;
    if (sb.busy_mask !== 32'h80) begin
      failures++;
      $display("FAIL soc_busy got=%h exp=%h", sb.busy_mask, 32'h80);
    end
    checks++;
    if (sb.pending_count !== 6'd1) begin
      failures++;
      $display("FAIL soc_pend got=%0d exp=1", sb.pending_count);
    end
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd7;
    step();
    idle_inputs();
    checks++;
    if (sb.busy_mask !== 32'h0 || sb.pending_count !== 6'd0) begin
      failures++;
      $display("FAIL soc_clear got=%h/%0d exp=0/0",
               sb.busy_mask, sb.pending_count);
    end
  endtask

  task automatic test_r0();
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    step();
    checks++;
    if (sb.busy_mask !== 32'h0) begin
      failures++;
      $display("FAIL r0_busy got=%h exp=0", sb.busy_mask);
    end
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd0;
    #1;
    checks++;
    if (sb.issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_stall got=%b exp=0", sb.issue_stall);
    end
    step();
    idle_inputs();
    checks++;
    if (sb.err_spurious !== 1'b0 || sb.busy_mask !== 32'h0) begin
      failures++;
      $display("FAIL r0_wb got=%b/%h exp=0/0",
               sb.err_spurious, sb.busy_mask);
    end
  endtask

  task automatic test_fill_flush();
    int nstall;
    nstall = 0;
    for (int d = 1; d < 32; d++) begin
      issue(1'b1, 5'(d), 5'd0, 5'd0);
      #1;
      if (sb.issue_stall !== 1'b0) nstall++;
      step();
    end
    idle_inputs();
    checks++;
    if (nstall != 0) begin
      failures++;
      $display("FAIL fill_stalls got=%0d exp=0", nstall);
    end
    checks++;
    if (sb.pending_count !== 6'd31) begin
      failures++;
      $display("FAIL fill_pend got=%0d exp=31", sb.pending_count);
    end
    checks++;
    if (sb.busy_mask !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL fill_busy got=%h exp=%h", sb.busy_mask, 32'hFFFF_FFFE);
    end
    sb.flush    = 1'b1;
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd4;
    issue(1'b1, 5'd3, 5'd0, 5'd0);
    #1;
    checks++;
    if (sb.issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL flush_stall got=%b exp=1", sb.issue_stall);
    end
    step();
    idle_inputs();
    checks++;
    if (sb.busy_mask !== 32'h0 || sb.pending_count !== 6'd0) begin
      failures++;
      $display("FAIL flush_clear got=%h/%0d exp=0/0",
               sb.busy_mask, sb.pending_count);
    end
    checks++;
    if (sb.err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL flush_err got=%b exp=0", sb.err_spurious);
    end
    checks++;
    if (sb.stall_cycles !== exp_cnt) begin
      failures++;
      $display("FAIL flush_cnt got=%h exp=%h", sb.stall_cycles, exp_cnt);
    end
  endtask

  task automatic test_spurious();
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd9;
    step();
    idle_inputs();
    checks++;
    if (sb.err_spurious !== 1'b1) begin
      failures++;
      $display("FAIL spur_set got=%b exp=1", sb.err_spurious);
    end
    repeat (2) step();
    checks++;
    if (sb.err_spurious !== 1'b1) begin
      failures++;
      $display("FAIL spur_sticky got=%b exp=1", sb.err_spurious);
    end
  endtask

  task automatic test_saturate();
    issue(1'b1, 5'd2, 5'd0, 5'd0);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd2);
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (sb.stall_cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_cnt got=%h exp=ffff", sb.stall_cycles);
    end
    step();
    checks++;
    if (sb.stall_cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_nowrap got=%h exp=ffff", sb.stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_final_reset();
    reset = 1'b1;
    sb.wb_valid = 1'b1;
    sb.wb_dest  = 5'd11;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (sb.stall_cycles !== 16'h0 || sb.err_spurious !== 1'b0
        || sb.busy_mask !== 32'h0) begin
      failures++;
      $display("FAIL rst_clear got=%h/%b/%h exp=0/0/0",
               sb.stall_cycles, sb.err_spurious, sb.busy_mask);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'h0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_raw();
    test_set_over_clear();
    test_r0();
    test_fill_flush();
    test_spurious();
    test_saturate();
    test_final_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Register-busy scoreboard that sequences issue into the 32x32 register file.
- Tracks which architectural registers have a write in flight between issue and writeback.
- Stalls issue on RAW/WAW hazards; clears busy bits as writeback lands on the register-file write port.
- Sits between decode/issue and the register file; pipeline flush clears all pending state.

Parameters:
NUM_REGS, 32, number of architectural registers; r0 is hardwired zero and never busy
REG_AW, 5, register index width (log2 NUM_REGS)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
flush  input  1  pipeline flush; discards all in-flight writes
issue_valid  input  1  decode presents an instruction this cycle
issue_writes  input  1  instruction writes a destination register
issue_dest  input  REG_AW  destination register index
issue_src1  input  REG_AW  first source register index
issue_src2  input  REG_AW  second source register index
issue_stall  output  1  combinational: instruction must be held this cycle
wb_valid  input  1  writeback commits to register file this cycle (same cycle as write_enable)
wb_dest  input  REG_AW  writeback register index
busy_mask  output  NUM_REGS  registered busy bit per register; bit 0 always 0
pending_count  output  REG_AW+1  registered number of busy registers
stall_cycles  output  CNT_W  registered saturating count of cycles with issue_valid & issue_stall
err_spurious  output  1  sticky: writeback arrived for a non-busy nonzero register

Behaviour:
- Reset (synchronous, clk rising edge with reset=1): busy_mask=0, pending_count=0, stall_cycles=0, err_spurious=0. Reset overrides flush, issue and wb.
- Effective busy (combinational): eff_busy[r] = busy_mask[r] & ~(wb_valid & wb_dest==r).
  - The register file writes on the falling edge and reads on the following rising edge, so a same-cycle writeback is already visible to a read.
- issue_stall = flush | (issue_valid & (eff_busy[src1] | eff_busy[src2] | (issue_writes & eff_busy[dest]))).
  - Register 0 never contributes, since its busy bit is constant 0.
  - Sources are checked regardless of instruction type; a false RAW on an unused source is accepted as conservative.
- issue_stall is 0 when issue_valid=0 and flush=0.
- Accept: accept = issue_valid & ~issue_stall.
- Next-state per register r, with priority reset > flush > set > clear:
  - flush=1: busy_mask <= 0 (all writebacks that cycle ignored, no error raised).
  - set: accept & issue_writes & issue_dest==r & r!=0 -> busy[r] <= 1. Set wins over a same-cycle clear of the same r, so the register stays busy for the new writer.
  - clear: wb_valid & wb_dest==r & r!=0 -> busy[r] <= 0.
- pending_count <= popcount of next busy_mask (registered, consistent with busy_mask every cycle). Max value NUM_REGS-1.
- stall_cycles increments by 1 when issue_valid & issue_stall & ~flush; saturates at all-ones, no wrap. Cleared only by reset.
- err_spurious <= 1 when wb_valid & wb_dest!=0 & busy_mask[wb_dest]==0 & ~flush; sticky until reset.
  - wb_dest==0 is silently ignored.
- Latency: busy bit visible on busy_mask 1 cycle after accept. A dependent instruction presented the very next cycle is stalled via registered busy_mask.
- Single issue and single writeback per cycle; no per-register counters. WAW is stalled, so at most one writer per register is in flight.
- Reset or flush mid-operation: any later writeback for a discarded register raises err_spurious after reset/flush only if it arrives with flush=0. The pipeline must squash those writebacks.

Test Plan:
- Reset then idle 3 cycles -> busy_mask=0, pending_count=0, issue_stall=0, stall_cycles=0, err_spurious=0.
- Issue dest=5 (writes=1) at cycle 0; cycle 1 issue src1=5 -> busy_mask=0x20, issue_stall=1, stall_cycles=1. wb_dest=5 at cycle 3 with dependent still presented -> issue_stall=0 that cycle, accepted.
- Same cycle: wb_dest=7 (busy) and accepted issue dest=7 -> busy_mask[7] stays 1, pending_count unchanged.
- Issue dest=0 writes=1, then src1=0 -> never stall, busy_mask stays 0. wb_dest=0 -> err_spurious stays 0.
- Fill dests 1..31 over 31 cycles -> pending_count=31. Assert flush one cycle with wb_valid dest=4 -> busy_mask=0, pending_count=0, err_spurious=0, issue_stall=1 during flush.
- wb_dest=9 with busy[9]=0 -> err_spurious=1 next cycle and remains 1. Hold stall for 70000 cycles at CNT_W=16 -> stall_cycles=0xFFFF.
